// File: rtl/synth_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | synth_pkg : constants and helpers shared by the synth output path        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package synth_pkg;

    // Sample width shared with the LUT generators.
    localparam int SAMPLE_WIDTH = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FADE = 1'b1;

    // $clog2 that never returns 0, so a single-entry index still has a bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wav_sel_xfade_btn_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btn_edge : 1-bit rising-edge detector; history resets high               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic press
);

    logic r_prev;

    // History resets to 1 so a button held through reset does not fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prev <= 1'b1;
        else        r_prev <= level;
    end

    assign press = level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/wav_sel_xfade.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wav_sel_xfade : waveform selector with inc/dec stepping and crossfade    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module wav_sel_xfade
    import synth_pkg::*;
#(
    parameter int WIDTH     = SAMPLE_WIDTH,
    parameter int NUM_WAVES = 4,
    parameter int FADE_LOG2 = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               sample_tick,
    input  logic [NUM_WAVES*WIDTH-1:0]         wav_in,
    input  logic                               inc,
    input  logic                               dec,
    output logic [clog2_min1(NUM_WAVES)-1:0]   sel,
    output logic                               busy,
    output logic [WIDTH-1:0]                   wav_out,
    output logic                               wav_valid
);

    localparam int SW = clog2_min1(NUM_WAVES);
    localparam int KW = (FADE_LOG2 > 0) ? FADE_LOG2 : 1;
    localparam int MW = WIDTH + FADE_LOG2 + 1;
    localparam logic [SW-1:0] SEL_LAST = SW'(NUM_WAVES - 1);
    localparam logic [KW-1:0] K_LAST   = KW'((1 << FADE_LOG2) - 1);
    localparam logic [MW-1:0] K_FULL   = MW'(1) << FADE_LOG2;

    logic [0:0]    r_state;
    logic [SW-1:0] r_src;
    logic [KW-1:0] r_k;

    logic          w_inc_press;
    logic          w_dec_press;
    logic [SW-1:0] w_inc_tgt;
    logic [SW-1:0] w_dec_tgt;
    logic [SW-1:0] w_target;
    logic [WIDTH-1:0] w_sel_wave;
    logic [WIDTH-1:0] w_src_wave;
    logic [MW-1:0]    w_mix;

    btn_edge u_inc_edge (.clk(clk), .rst_n(rst_n), .level(inc), .press(w_inc_press));
    btn_edge u_dec_edge (.clk(clk), .rst_n(rst_n), .level(dec), .press(w_dec_press));

    assign w_inc_tgt = (sel == SEL_LAST) ? '0 : sel + 1'b1;
    assign w_dec_tgt = (sel == '0) ? SEL_LAST : sel - 1'b1;

    // Simultaneous inc+dec cancel out: target falls back to the current sel.
    always_comb begin
        w_target = sel;
        if (w_inc_press && !w_dec_press)      w_target = w_inc_tgt;
        else if (w_dec_press && !w_inc_press) w_target = w_dec_tgt;
    end

    assign w_sel_wave = wav_in[int'(sel)   * WIDTH +: WIDTH];
    assign w_src_wave = wav_in[int'(r_src) * WIDTH +: WIDTH];

    assign w_mix = ( MW'(w_src_wave) * (K_FULL - MW'(r_k))
                   + MW'(w_sel_wave) * MW'(r_k) ) >> FADE_LOG2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            sel       <= '0;
            r_src     <= '0;
            r_k       <= '0;
            busy      <= 1'b0;
            wav_out   <= '0;
            wav_valid <= 1'b0;
        end else begin
            wav_valid <= sample_tick;
            case (r_state)
                ST_IDLE: begin
                    if (sample_tick) wav_out <= w_sel_wave;
                    if (w_target != sel) begin
                        sel <= w_target;
                        if (FADE_LOG2 > 0) begin
                            r_src   <= sel;
                            r_k     <= '0;
                            r_state <= ST_FADE;
                            busy    <= 1'b1;
                        end
                    end
                end
                ST_FADE: begin
                    // Presses are ignored here; the edge detectors keep tracking.
                    if (sample_tick) begin
                        wav_out <= w_mix[WIDTH-1:0];
                        r_k     <= r_k + 1'b1;
                        if (r_k == K_LAST) begin
                            r_src   <= sel;
                            r_k     <= '0;
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wav_sel_xfade.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wav_sel_xfade : directed bench, instances with FADE_LOG2 = 0, 2, 4    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_wav_sel_xfade;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        inc = 1'b0;
    logic        dec = 1'b0;
    logic [31:0] wav_in = '0;

    logic [1:0] sel0, sel2, sel4;
    logic       busy0, busy2, busy4;
    logic [7:0] out0, out2, out4;
    logic       val0, val2, val4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wav_sel_xfade #(.WIDTH(8), .NUM_WAVES(4), .FADE_LOG2(0)) u_f0 (
        .clk(clk), .rst_n(rst_n), .sample_tick(tick), .wav_in(wav_in),
        .inc(inc), .dec(dec), .sel(sel0), .busy(busy0), .wav_out(out0), .wav_valid(val0));
    wav_sel_xfade #(.WIDTH(8), .NUM_WAVES(4), .FADE_LOG2(2)) u_f2 (
        .clk(clk), .rst_n(rst_n), .sample_tick(tick), .wav_in(wav_in),
        .inc(inc), .dec(dec), .sel(sel2), .busy(busy2), .wav_out(out2), .wav_valid(val2));
    wav_sel_xfade #(.WIDTH(8), .NUM_WAVES(4), .FADE_LOG2(4)) u_f4 (
        .clk(clk), .rst_n(rst_n), .sample_tick(tick), .wav_in(wav_in),
        .inc(inc), .dec(dec), .sel(sel4), .busy(busy4), .wav_out(out4), .wav_valid(val4));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; inc = 1'b0; dec = 1'b0; tick = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; inc = 1'b1; dec = 1'b0; tick = 1'b0;
        step(); step(); step();
        rst_n = 1'b1;
        step(); step(); step();
        n_vec++; if (sel0 !== 2'd0) begin n_err++; $display("FAIL reset_sel got %0d want 0", sel0); end
        n_vec++; if (out0 !== 8'h00) begin n_err++; $display("FAIL reset_out got %0h want 00", out0); end
        n_vec++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy4); end
        n_vec++; if (val0 !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", val0); end
        inc = 1'b0; step();
        inc = 1'b1; step();
        n_vec++; if (sel0 !== 2'd1) begin n_err++; $display("FAIL reset_repress got %0d want 1", sel0); end
        do_reset();
    endtask

    task automatic test_wrap();
        logic [1:0] exp_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        wav_in = {8'h40, 8'h30, 8'h20, 8'h10};
        for (int i = 0; i < 4; i++) begin
            inc = 1'b1; step();
            n_vec++; if (sel0 !== exp_sel[i]) begin n_err++; $display("FAIL wrap_inc%0d got %0d want %0d", i, sel0, exp_sel[i]); end
            inc = 1'b0; step();
        end
        n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL wrap_busy got %0b want 0", busy0); end
        do_tick();
        n_vec++; if (out0 !== 8'h10) begin n_err++; $display("FAIL wrap_out0 got %0h want 10", out0); end
        dec = 1'b1; step();
        n_vec++; if (sel0 !== 2'd3) begin n_err++; $display("FAIL wrap_dec got %0d want 3", sel0); end
        dec = 1'b0; step();
        do_tick();
        n_vec++; if (out0 !== 8'h40) begin n_err++; $display("FAIL wrap_out3 got %0h want 40", out0); end
    endtask

    task automatic test_fade();
        logic [7:0] exp_out [4] = '{8'd0, 8'd50, 8'd100, 8'd150};
        do_reset();
        wav_in = {8'd0, 8'd0, 8'd200, 8'd0};
        inc = 1'b1; step(); inc = 1'b0;
        n_vec++; if (busy2 !== 1'b1) begin n_err++; $display("FAIL fade_busy_start got %0b want 1", busy2); end
        n_vec++; if (sel2 !== 2'd1) begin n_err++; $display("FAIL fade_sel got %0d want 1", sel2); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (busy2 !== 1'b1) begin n_err++; $display("FAIL fade_busy_k%0d got %0b want 1", i, busy2); end
            do_tick();
            n_vec++; if (out2 !== exp_out[i]) begin n_err++; $display("FAIL fade_out_k%0d got %0d want %0d", i, out2, exp_out[i]); end
            n_vec++; if (val2 !== 1'b1) begin n_err++; $display("FAIL fade_valid_k%0d got %0b want 1", i, val2); end
            step();
            n_vec++; if (out2 !== exp_out[i]) begin n_err++; $display("FAIL fade_hold_k%0d got %0d want %0d", i, out2, exp_out[i]); end
            n_vec++; if (val2 !== 1'b0) begin n_err++; $display("FAIL fade_valid_low_k%0d got %0b want 0", i, val2); end
        end
        n_vec++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL fade_busy_end got %0b want 0", busy2); end
        do_tick();
        n_vec++; if (out2 !== 8'd200) begin n_err++; $display("FAIL fade_out_final got %0d want 200", out2); end
    endtask

    task automatic test_simultaneous();
        inc = 1'b1; dec = 1'b1; step();
        n_vec++; if (sel2 !== 2'd1) begin n_err++; $display("FAIL simul_sel got %0d want 1", sel2); end
        n_vec++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL simul_busy got %0b want 0", busy2); end
        step();
        n_vec++; if (sel0 !== 2'd1) begin n_err++; $display("FAIL simul_sel_hard got %0d want 1", sel0); end
        inc = 1'b0; dec = 1'b0; step();
    endtask

    task automatic test_press_during_fade();
        do_reset();
        wav_in = {8'd0, 8'd0, 8'd160, 8'd0};
        inc = 1'b1; step(); inc = 1'b0; step();
        for (int i = 0; i < 16; i++) begin
            if (i == 3)  inc = 1'b1;
            if (i == 15) dec = 1'b1;
            do_tick();
            inc = 1'b0; dec = 1'b0;
            if (i == 3) begin
                n_vec++; if (out4 !== 8'd30) begin n_err++; $display("FAIL pfade_out_k3 got %0d want 30", out4); end
                n_vec++; if (sel4 !== 2'd1) begin n_err++; $display("FAIL pfade_sel_k3 got %0d want 1", sel4); end
            end
        end
        step();
        n_vec++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL pfade_busy_end got %0b want 0", busy4); end
        n_vec++; if (sel4 !== 2'd1) begin n_err++; $display("FAIL pfade_sel_end got %0d want 1", sel4); end
        do_tick();
        n_vec++; if (out4 !== 8'd160) begin n_err++; $display("FAIL pfade_out_final got %0d want 160", out4); end
    endtask

    task automatic test_reset_mid_fade();
        do_reset();
        wav_in = {8'd0, 8'd0, 8'd160, 8'd0};
        inc = 1'b1; step(); inc = 1'b0; step();
        for (int i = 0; i < 5; i++) begin
            do_tick();
            n_vec++; if (val4 !== 1'b1) begin n_err++; $display("FAIL rmid_valid_k%0d got %0b want 1", i, val4); end
            step();
            n_vec++; if (val4 !== 1'b0) begin n_err++; $display("FAIL rmid_valid_low_k%0d got %0b want 0", i, val4); end
        end
        n_vec++; if (out4 !== 8'd40) begin n_err++; $display("FAIL rmid_out_k4 got %0d want 40", out4); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %0b want 0", busy4); end
        n_vec++; if (sel4 !== 2'd0) begin n_err++; $display("FAIL rmid_sel got %0d want 0", sel4); end
        n_vec++; if (out4 !== 8'd0) begin n_err++; $display("FAIL rmid_out got %0d want 0", out4); end
        step();
        rst_n = 1'b1;
        step();
        wav_in = {8'd0, 8'd0, 8'd160, 8'd77};
        do_tick();
        n_vec++; if (out4 !== 8'd77) begin n_err++; $display("FAIL rmid_no_resume got %0d want 77", out4); end
        n_vec++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL rmid_busy_after got %0b want 0", busy4); end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_fade();
        test_simultaneous();
        test_press_during_fade();
        test_reset_mid_fade();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
